// File: rtl/hazard_sb_if.sv
// Hazard unit <-> datapath bundle: decode/execute operands, post-E writeback taps, stall/flush controls.
// master = datapath side, slave = hazard_sb.
interface hazard_sb_if #(
  parameter int REG_AW = 5,
  parameter int NFWD   = 2
);
  localparam int SEL_W = $clog2(NFWD + 1);

  logic [REG_AW-1:0]      rsD;
  logic [REG_AW-1:0]      rtD;
  logic                   regwriteD;
  logic [REG_AW-1:0]      writeregD;
  logic                   branchD;
  logic                   forwardaD;
  logic                   forwardbD;
  logic [REG_AW-1:0]      rsE;
  logic [REG_AW-1:0]      rtE;
  logic [REG_AW-1:0]      writeregE;
  logic                   regwriteE;
  logic                   memtoregE;
  logic                   mc_issueE;
  logic                   div_stallE;
  logic [SEL_W-1:0]       forwardaE;
  logic [SEL_W-1:0]       forwardbE;
  logic [NFWD-1:0]        fwd_regwrite;
  logic [NFWD*REG_AW-1:0] fwd_writereg;
  logic                   memtoregM;
  logic                   mc_done;
  logic [REG_AW-1:0]      mc_donereg;
  logic                   except_flush;
  logic                   stallF, stallD, stallE, stallM, stallW;
  logic                   flushF, flushD, flushE, flushM, flushW;
  logic                   sb_full;

  modport master (
    output rsD, rtD, regwriteD, writeregD, branchD,
    output rsE, rtE, writeregE, regwriteE, memtoregE, mc_issueE, div_stallE,
    output fwd_regwrite, fwd_writereg, memtoregM, mc_done, mc_donereg, except_flush,
    input  forwardaD, forwardbD, forwardaE, forwardbE,
    input  stallF, stallD, stallE, stallM, stallW,
    input  flushF, flushD, flushE, flushM, flushW, sb_full
  );

  modport slave (
    input  rsD, rtD, regwriteD, writeregD, branchD,
    input  rsE, rtE, writeregE, regwriteE, memtoregE, mc_issueE, div_stallE,
    input  fwd_regwrite, fwd_writereg, memtoregM, mc_done, mc_donereg, except_flush,
    output forwardaD, forwardbD, forwardaE, forwardbE,
    output stallF, stallD, stallE, stallM, stallW,
    output flushF, flushD, flushE, flushM, flushW, sb_full
  );
endinterface

// File: rtl/hazard_sb.sv
// Hazard unit: NFWD-deep forwarding, load-use/branch stalls, multi-cycle writer scoreboard (WAW stall under HAZARD_SB_WAW_EN).
// Latency: selects/stalls/flushes combinational; pend visible next cycle; sb_full one edge behind cnt.
// Backpressure: stalls Decode on pending sources, Execute when MC_MAX ops are outstanding.
module hazard_sb #(
  parameter int REG_AW = 5,
  parameter int NFWD   = 2,
  parameter int MC_MAX = 4
) (
  input logic        clk,
  input logic        resetn,
  hazard_sb_if.slave hz
);
  localparam int NREG  = 1 << REG_AW;
  localparam int CNT_W = $clog2(MC_MAX + 1);
  localparam int SEL_W = $clog2(NFWD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MC_MAX);

  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pendNext;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cntNext;
  logic              sbFullQ;
  logic [REG_AW-1:0] fwdReg [NFWD];
  logic [SEL_W-1:0]  selA;
  logic [SEL_W-1:0]  selB;
  logic              iss;
  logic              doneOk;
  logic              eHit;
  logic              mHit;
  logic              lwStall;
  logic              brStall;
  logic              srcStall;
  logic              wawStall;
  logic              sbStall;
  logic              fullStall;
  logic              stallEInt;
  logic              stallDInt;

  always_comb begin
    for (int k = 0; k < NFWD; k++) begin
      fwdReg[k] = hz.fwd_writereg[k*REG_AW +: REG_AW];
    end
  end

  // Walk from the oldest stage down so the youngest (lowest k) match wins.
  always_comb begin
    selA = '0;
    selB = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (hz.fwd_regwrite[k] && hz.rsE != '0 && fwdReg[k] == hz.rsE) selA = SEL_W'(k + 1);
      if (hz.fwd_regwrite[k] && hz.rtE != '0 && fwdReg[k] == hz.rtE) selB = SEL_W'(k + 1);
    end
  end

  assign hz.forwardaE = selA;
  assign hz.forwardbE = selB;
  assign hz.forwardaD = (hz.rsD != '0) && (hz.rsD == fwdReg[0]) && hz.fwd_regwrite[0];
  assign hz.forwardbD = (hz.rtD != '0) && (hz.rtD == fwdReg[0]) && hz.fwd_regwrite[0];

  assign eHit    = (hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD);
  assign mHit    = (fwdReg[0] == hz.rsD) || (fwdReg[0] == hz.rtD);
  assign lwStall = hz.memtoregE && hz.regwriteE && (hz.writeregE != '0) && eHit;
  assign brStall = hz.branchD &&
                   ((hz.regwriteE && (hz.writeregE != '0) && eHit) ||
                    (hz.memtoregM && hz.fwd_regwrite[0] && mHit));

  assign srcStall = ((hz.rsD != '0) && pend[hz.rsD]) || ((hz.rtD != '0) && pend[hz.rtD]);
`ifdef HAZARD_SB_WAW_EN
  // A younger write to a pending register must wait, or the late completion would clobber it.
  assign wawStall = hz.regwriteD && (hz.writeregD != '0) && pend[hz.writeregD];
`else
  logic unusedWaw;
  assign unusedWaw = &{1'b0, hz.regwriteD, hz.writeregD};
  assign wawStall  = 1'b0;
`endif
  assign sbStall = srcStall || wawStall;

  // A completion in the same cycle frees the slot the new issue needs.
  assign fullStall = hz.mc_issueE && (cnt == CNT_MAX) && !hz.mc_done;
  assign stallEInt = hz.div_stallE || fullStall;
  assign stallDInt = lwStall || brStall || sbStall || stallEInt;

  assign hz.stallE = stallEInt;
  assign hz.stallD = stallDInt;
  assign hz.stallF = stallDInt;
  assign hz.stallM = hz.div_stallE;
  assign hz.stallW = hz.div_stallE;

  assign hz.flushF = hz.except_flush;
  assign hz.flushD = hz.except_flush;
  assign hz.flushW = hz.except_flush;
  assign hz.flushE = (stallDInt && !stallEInt) || hz.except_flush;
  assign hz.flushM = (fullStall && !hz.div_stallE) || hz.except_flush;

  assign hz.sb_full = sbFullQ;

  assign iss    = hz.mc_issueE && hz.regwriteE && (hz.writeregE != '0) && !stallEInt && !hz.except_flush;
  assign doneOk = hz.mc_done && (cnt != '0);

  // Clear first so a same-register issue in the same cycle keeps the bit set.
  always_comb begin
    pendNext = pend;
    if (doneOk) pendNext[hz.mc_donereg] = 1'b0;
    if (iss)    pendNext[hz.writeregE]  = 1'b1;
    case ({iss, doneOk})
      2'b10:   cntNext = cnt + CNT_W'(1);
      2'b01:   cntNext = cnt - CNT_W'(1);
      default: cntNext = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend    <= '0;
      cnt     <= '0;
      sbFullQ <= 1'b0;
    end else begin
      pend    <= pendNext;
      cnt     <= cntNext;
      sbFullQ <= (cnt == CNT_MAX);
    end
  end
endmodule
